tile_memory_reader: RTL
=======================

Name: tile_memory_reader

Overview:
- Read-side sequencer for the 36-entry x 4-bit tile SRAM (24 edge tiles, 12 center tiles).
- On a START pulse it sweeps the SRAM address 0..35 and captures each returned nibble.
- It repacks the nibbles into the same 96-bit edge and 48-bit center bus layout the SRAM write port accepts, so write followed by read is an identity round trip.
- Sits between the tile SRAM and the game-logic and display blocks, which consume full-board snapshots.

Parameters:
- NUM_EDGE, 24, number of edge tiles (SRAM addresses 0..NUM_EDGE-1).
- NUM_CENTER, 12, number of center tiles (addresses NUM_EDGE..NUM_EDGE+NUM_CENTER-1).
- DW, 4, tile data width in bits.
- AW, 6, SRAM address width.
- RD_LAT, 0, SRAM read latency in cycles. Legal values are 0, 1 and 2; 0 means combinational read.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- START  input  1  request one full sweep; sampled only in IDLE.
- ADDR  output  AW  SRAM read address.
- DATA_IN  input  DW  SRAM read data.
- BUSY  output  1  high from the cycle after START is accepted until DONE.
- DONE  output  1  one-cycle pulse; the snapshot outputs are valid from this cycle on.
- EDGE_DATA_OUT  output  NUM_EDGE*DW  packed edge snapshot.
- CENTER_DATA_OUT  output  NUM_CENTER*DW  packed center snapshot.

Behaviour:
- Reset (rst sampled high): state IDLE. ADDR=0, BUSY=0, DONE=0, EDGE_DATA_OUT=0, CENTER_DATA_OUT=0, all counters and pipeline valids cleared.
  - Reset mid-sweep aborts immediately; no DONE is produced and partial data is discarded (outputs read 0).
- States:
  - IDLE: START=1 -> READ with ADDR=0, BUSY=1.
  - READ: ADDR increments by 1 each cycle. After ADDR=35 is issued -> DRAIN if RD_LAT>0, otherwise -> FIN.
  - DRAIN: wait RD_LAT cycles for in-flight reads -> FIN.
  - FIN: DONE=1 for one cycle, BUSY=0 -> IDLE.
- Capture:
  - A valid shift chain of depth RD_LAT carries each issued address index alongside the read.
  - DATA_IN is written into the snapshot slot for the index emerging from the chain; for RD_LAT=0 it is written in the same cycle ADDR is presented.
- Packing:
  - Index i < NUM_EDGE -> EDGE_DATA_OUT[(NUM_EDGE-i)*DW-1 -: DW]; index 0 maps to bits [95:92].
  - Index NUM_EDGE+j -> CENTER_DATA_OUT[(NUM_CENTER-j)*DW-1 -: DW]; index 24 maps to bits [47:44].
- Snapshot registers update in place during the sweep. Consumers use them only after DONE; they hold until the next accepted START or reset.
- Latency: START accepted at edge 0 -> DONE high in cycle 37+RD_LAT. The next START is accepted in the cycle after DONE.
- START while BUSY or DONE is ignored; it is not queued.
- ADDR wraps back to 0 in FIN and stays 0 in IDLE. An address above 35 is never issued.
- If the SRAM is written during a sweep, the snapshot is a mix of old and new contents. Callers serialise writes against BUSY.

Optional Feature:
- Macro: TILE_READER_CHECKSUM_EN.
- Defined:
  - Adds output CHECKSUM [DW-1:0], the XOR of all 36 captured nibbles.
  - CHECKSUM is cleared on accepted START and accumulated per capture. It is valid and held from DONE on, and reset to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package tile_mem_pkg holds:
  - constants NUM_EDGE, NUM_CENTER, NUM_TILES=36, DW, AW;
  - the reader state enum (IDLE, READ, DRAIN, FIN);
  - the nibble-slot index helper constants.
- The SRAM writer uses the same package, so both ends share one layout.
- One sub-module is natural: tile_rd_pipe, the RD_LAT-deep valid/index delay line. The FSM and packing stay in the top.

Test Plan:
- Preload SRAM so address k holds k mod 16, RD_LAT=0, pulse START -> DONE at cycle 37; EDGE_DATA_OUT=0x0123456789ABCDEF01234567; CENTER_DATA_OUT=0x89ABCDEF0123; BUSY high in cycles 1-36.
- Same preload, RD_LAT=2 with a 2-cycle registered SRAM model -> DONE at cycle 39, identical packed outputs.
- Write EDGE=0xFFF...F, CENTER=0x5A5A5A5A5A5A, then sweep -> readback equals the written buses. With TILE_READER_CHECKSUM_EN, CHECKSUM=0x0 (24 x 0xF XOR 6 x 0x5 XOR 6 x 0xA = 0).
- Pulse START again at cycles 5 and 20 while BUSY -> exactly one DONE, at cycle 37.
- Assert rst at cycle 15 of a sweep -> next cycle BUSY=0, DONE=0, ADDR=0, outputs 0; no DONE follows. A subsequent START completes normally.
- START held high continuously -> back-to-back sweeps. DONE pulses at cycles 37, 75, 113 (period 38); ADDR never exceeds 35.

Source files
------------

// File: rtl/tile_mem_pkg.sv
// Shared layout for the 36-entry x 4-bit tile SRAM: sizes, reader FSM states
// and the nibble-slot helpers used by both the writer and the reader.
package tile_mem_pkg;

    localparam int NUM_EDGE    = 24;
    localparam int NUM_CENTER  = 12;
    localparam int NUM_TILES   = NUM_EDGE + NUM_CENTER;
    localparam int DW          = 4;
    localparam int AW          = 6;
    localparam int EDGE_BITS   = NUM_EDGE * DW;
    localparam int CENTER_BITS = NUM_CENTER * DW;

    localparam logic [AW-1:0] FIRST_EDGE_ADDR   = '0;
    localparam logic [AW-1:0] FIRST_CENTER_ADDR = AW'(NUM_EDGE);
    localparam logic [AW-1:0] LAST_ADDR         = AW'(NUM_TILES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } rd_state_e;

    // Tile 0 sits in the most significant nibble of its bus.
    function automatic int edge_slot_lsb(input int i);
        return (NUM_EDGE - 1 - i) * DW;
    endfunction

    function automatic int center_slot_lsb(input int j);
        return (NUM_CENTER - 1 - j) * DW;
    endfunction

endpackage

// File: rtl/tile_rd_pipe.sv
// RD_LAT-deep delay line that carries each issued read index alongside the
// SRAM access so the returning nibble lands in the right slot.
module tile_rd_pipe
    import tile_mem_pkg::*;
#(
    parameter int RD_LAT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [AW-1:0] in_idx,
    output logic          out_valid,
    output logic [AW-1:0] out_idx
);

    generate
        if (RD_LAT == 0) begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk, rst};
            assign out_valid = in_valid;
            assign out_idx   = in_idx;
        end else begin : g_pipe
            logic [RD_LAT-1:0] v_q;
            logic [AW-1:0]     idx_q [RD_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= '0;
                    for (int s = 0; s < RD_LAT; s++) begin
                        idx_q[s] <= '0;
                    end
                end else begin
                    v_q[0]   <= in_valid;
                    idx_q[0] <= in_idx;
                    for (int s = 1; s < RD_LAT; s++) begin
                        v_q[s]   <= v_q[s-1];
                        idx_q[s] <= idx_q[s-1];
                    end
                end
            end

            assign out_valid = v_q[RD_LAT-1];
            assign out_idx   = idx_q[RD_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/tile_memory_reader.sv
// Sweeps the tile SRAM once per START and repacks the nibbles into the edge and
// center buses. Optional CHECKSUM output with `define TILE_READER_CHECKSUM_EN.
module tile_memory_reader
    import tile_mem_pkg::*;
#(
    parameter int RD_LAT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   START,
    output logic [AW-1:0]          ADDR,
    input  logic [DW-1:0]          DATA_IN,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [EDGE_BITS-1:0]   EDGE_DATA_OUT,
    output logic [CENTER_BITS-1:0] CENTER_DATA_OUT,
    output logic [1:0]             state_dbg
`ifdef TILE_READER_CHECKSUM_EN
    ,
    output logic [DW-1:0]          CHECKSUM
`endif
);

    // START is a request sampled only in IDLE (no queueing); DONE is a single
    // cycle completion pulse and the snapshot holds from then until next START.
    rd_state_e             state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [1:0]            drain_q, drain_d;
    logic                  start_acc;
    logic                  issue_valid;
    logic                  cap_valid;
    logic [AW-1:0]         cap_idx;
    logic [EDGE_BITS-1:0]  edge_q;
    logic [CENTER_BITS-1:0] center_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        drain_d   = drain_q;
        start_acc = 1'b0;
        case (state_q)
            IDLE: begin
                addr_d = FIRST_EDGE_ADDR;
                if (START) begin
                    start_acc = 1'b1;
                    state_d   = READ;
                end
            end
            READ: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    drain_d = '0;
                    state_d = (RD_LAT > 0) ? DRAIN : FIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == 2'(RD_LAT - 1)) begin
                    state_d = FIN;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            FIN: begin
                addr_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ADDR        = addr_q;
    assign BUSY        = (state_q == READ) || (state_q == DRAIN);
    assign DONE        = (state_q == FIN);
    assign state_dbg   = state_q;
    assign issue_valid = (state_q == READ);

    tile_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue_valid),
        .in_idx    (addr_q),
        .out_valid (cap_valid),
        .out_idx   (cap_idx)
    );

    // Slots are overwritten in place; nothing is cleared on START.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_q   <= '0;
            center_q <= '0;
        end else if (cap_valid) begin
            for (int i = 0; i < NUM_EDGE; i++) begin
                if (cap_idx == AW'(i)) begin
                    edge_q[edge_slot_lsb(i) +: DW] <= DATA_IN;
                end
            end
            for (int j = 0; j < NUM_CENTER; j++) begin
                if (cap_idx == FIRST_CENTER_ADDR + AW'(j)) begin
                    center_q[center_slot_lsb(j) +: DW] <= DATA_IN;
                end
            end
        end
    end

    assign EDGE_DATA_OUT   = edge_q;
    assign CENTER_DATA_OUT = center_q;

`ifdef TILE_READER_CHECKSUM_EN
    logic [DW-1:0] csum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else if (start_acc) begin
            csum_q <= '0;
        end else if (cap_valid) begin
            csum_q <= csum_q ^ DATA_IN;
        end
    end

    assign CHECKSUM = csum_q;
`endif

endmodule
